uart_dump_arbiter: RTL
======================

Name: uart_dump_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_tx instance and one synchronous RAM read port between NUM_REQ dump requesters.
Each requester asks for a contiguous RAM window (base, length) to be streamed out over UART.
The block grants one requester at a time, walks the RAM addresses, feeds bytes to uart_tx with the tx_do/send_ok handshake, and pulses a per-requester done.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 15, RAM address width
LEN_W, 15, transfer length width (bytes)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  level request per requester; held high until done
base_addr  in  NUM_REQ*ADDR_W  packed start addresses; requester i at [i*ADDR_W +: ADDR_W]
length  in  NUM_REQ*LEN_W  packed byte counts; requester i at [i*LEN_W +: LEN_W]
ram_addr  out  ADDR_W  RAM read address; data valid on ram_data one cycle later
ram_data  in  8  RAM read data
tx_data  out  8  byte to uart_tx
tx_do  out  1  send request to uart_tx; held until send_ok
send_ok  in  1  uart_tx completion pulse, one cycle
grant  out  NUM_REQ  one-hot current owner; 0 when idle
done  out  NUM_REQ  one-cycle pulse on completion of requester i
busy  out  1  high from grant to end of transfer

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; internal counters 0.
- Base and length are sampled once, at grant; later changes are ignored.
- States:
  - IDLE: if any req, pick the first set bit at or after ptr, cyclically. Set grant, busy=1, latch addr=base, rem=length. Go to ARB.
  - ARB: if rem==0, go to FIN (no bytes sent). Else drive ram_addr=addr, go to FETCH.
  - FETCH: tx_data<=ram_data, go to SEND.
  - SEND: tx_do=1 until send_ok. On send_ok: tx_do<=0, addr<=addr+1, rem<=rem-1. Go to GAP.
  - GAP: two idle cycles (tx_do low). Then, if rem==0, go to FIN; else drive ram_addr=addr and go to FETCH.
  - FIN: done[i] pulse one cycle; grant<=0, busy<=0; ptr<=i+1 mod NUM_REQ. Go to IDLE.
- Fairness: ptr advances past the last served requester. A requester still holding req after done waits for the others.
- Address counter wraps modulo 2^ADDR_W and is not flagged.
- Abort: if req[i] of the owner drops during ARB/FETCH/GAP, go to IDLE. No done pulse; grant and busy clear; ptr advances.
- If req[i] drops in SEND, the current byte completes (wait for send_ok), then abort as above. tx_do is never withdrawn before send_ok.
- A send_ok outside SEND is ignored.
- Simultaneous new req and FIN: the new req is considered in the IDLE cycle after FIN. There is a minimum one idle cycle between grants.
- Asynchronous reset mid-transfer: immediate return to reset values. A uart_tx in flight is not tracked.
- tx_data is stable for the whole SEND state.

Optional Feature:
DUMP_HEADER_EN
- Defined: after ARB, before the first data byte, send one header byte 8'hA0 | i (requester index), using the same SEND/GAP handshake.
  - Sent even when length==0 (FIN follows the header).
  - An abort during the header behaves like a data-byte abort.
- Undefined: no header; only RAM bytes are sent; length==0 sends nothing.

Test Plan:
- Single request: req=4'b0001, base0=0x0010, length0=3, uart_tx model acks 10 cycles after tx_do → tx_data sequence RAM[0x10..0x12], ram_addr 0x10,0x11,0x12, done[0] pulses once, grant returns to 0.
- Round-robin: req=4'b1011 held, length=1 each → grant order 0,1,3,0,1,3; each done pulse matches its grant; no requester served twice in a row while others wait.
- Zero length: req[2]=1, length2=0 → done[2] within 4 cycles of grant, tx_do never asserted (header 8'hA2 sent if DUMP_HEADER_EN).
- Abort in SEND: length0=5, drop req[0] while tx_do high on byte 2 → tx_do stays high until send_ok, no further bytes sent, no done[0], grant cleared.
- Address wrap: base=0x7FFE, length=4 → ram_addr 0x7FFE,0x7FFF,0x0000,0x0001, done asserted.
- Reset mid-transfer: assert reset low during GAP → tx_do, grant, busy, done, ram_addr all 0 immediately; after release with req=4'b0100, requester 2 granted first (ptr=0).

Source files
------------

// File: rtl/uart_dump_arbiter.sv
// rtl/uart_dump_arbiter.sv - round-robin sequencer streaming RAM windows from NUM_REQ requesters to one uart_tx
// Optional feature: define DUMP_HEADER_EN to prefix each transfer with header byte 8'hA0 | requester index.

module uart_dump_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 15,
   parameter int LEN_W   = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] base_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  length,
   output logic [ADDR_W-1:0]         ram_addr,
   input  logic [7:0]                ram_data,
   output logic [7:0]                tx_data,
   output logic                      tx_do,
   input  logic                      send_ok,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_FETCH,
      S_SEND,
      S_GAP,
      S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               gap_q, gap_d;
   logic               abort_q, abort_d;
`ifdef DUMP_HEADER_EN
   logic               hdr_pend_q, hdr_pend_d;
   logic               hdr_cur_q, hdr_cur_d;
`endif

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic [IDX_W:0]     rr_sum;
   logic               owner_req;
   logic               do_abort;

   logic [ADDR_W-1:0]  base_arr [NUM_REQ];
   logic [LEN_W-1:0]   len_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign base_arr[g] = base_addr[g*ADDR_W +: ADDR_W];
      assign len_arr[g]  = length[g*LEN_W +: LEN_W];
   end

   function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + IDX_W'(1);
   endfunction

   assign owner_req = req[owner_q];

   // First requester at or after ptr, scanning cyclically.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      rr_sum     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
         end
         if (!pick_found && req[rr_sum[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = rr_sum[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      tx_data_d = tx_data_q;
      gap_d     = gap_q;
      abort_d   = abort_q;
      do_abort  = 1'b0;
`ifdef DUMP_HEADER_EN
      hdr_pend_d = hdr_pend_q;
      hdr_cur_d  = hdr_cur_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               grant_d = NUM_REQ'(1) << pick_idx;
               addr_d  = base_arr[pick_idx];
               rem_d   = len_arr[pick_idx];
               gap_d   = 1'b0;
               abort_d = 1'b0;
`ifdef DUMP_HEADER_EN
               hdr_pend_d = 1'b1;
               hdr_cur_d  = 1'b0;
`endif
               state_d = S_ARB;
            end
         end

         S_ARB: begin
            if (!owner_req) begin
               do_abort = 1'b1;
            end else
`ifdef DUMP_HEADER_EN
            if (hdr_pend_q) begin
               tx_data_d  = 8'hA0 | 8'(owner_q);
               hdr_pend_d = 1'b0;
               hdr_cur_d  = 1'b1;
               state_d    = S_SEND;
            end else
`endif
            if (rem_q == '0) begin
               state_d = S_FIN;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            if (!owner_req) begin
               do_abort = 1'b1;
            end else begin
               tx_data_d = ram_data;
               state_d   = S_SEND;
            end
         end

         // A dropped request is remembered; the byte on the wire is still finished.
         S_SEND: begin
            if (!owner_req) begin
               abort_d = 1'b1;
            end
            if (send_ok) begin
               if (abort_q || !owner_req) begin
                  do_abort = 1'b1;
               end else begin
                  gap_d   = 1'b0;
                  state_d = S_GAP;
`ifdef DUMP_HEADER_EN
                  if (hdr_cur_q) begin
                     hdr_cur_d = 1'b0;
                  end else
`endif
                  begin
                     addr_d = addr_q + ADDR_W'(1);
                     rem_d  = rem_q - LEN_W'(1);
                  end
               end
            end
         end

         S_GAP: begin
            if (!owner_req) begin
               do_abort = 1'b1;
            end else if (!gap_q) begin
               gap_d = 1'b1;
            end else if (rem_q == '0) begin
               state_d = S_FIN;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_FIN: begin
            grant_d = '0;
            ptr_d   = inc_wrap(owner_q);
            state_d = S_IDLE;
         end

         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase

      if (do_abort) begin
         grant_d = '0;
         ptr_d   = inc_wrap(owner_q);
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         grant_q   <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         tx_data_q <= '0;
         gap_q     <= 1'b0;
         abort_q   <= 1'b0;
`ifdef DUMP_HEADER_EN
         hdr_pend_q <= 1'b0;
         hdr_cur_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         grant_q   <= grant_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         tx_data_q <= tx_data_d;
         gap_q     <= gap_d;
         abort_q   <= abort_d;
`ifdef DUMP_HEADER_EN
         hdr_pend_q <= hdr_pend_d;
         hdr_cur_q  <= hdr_cur_d;
`endif
      end
   end

   assign ram_addr = addr_q;
   assign tx_data  = tx_data_q;
   assign tx_do    = (state_q == S_SEND);
   assign grant    = grant_q;
   assign done     = (state_q == S_FIN) ? grant_q : '0;
   assign busy     = |grant_q;

endmodule
